// File: rtl/hazard_ctrl_md.sv
// Tuse/Tnew stall and forwarding controller for a 5-stage MIPS pipeline, with a
// multiply/divide busy sequencer and a saturating stall-cycle counter.
module hazard_ctrl_md #(
   parameter int RAW      = 5,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [RAW-1:0]   D_A1,
   input  logic [RAW-1:0]   D_A2,
   input  logic [1:0]       D_tuse1,
   input  logic [1:0]       D_tuse2,
   input  logic             D_is_md,
   input  logic [RAW-1:0]   E_A1,
   input  logic [RAW-1:0]   E_A2,
   input  logic [RAW-1:0]   M_A2,
   input  logic [RAW-1:0]   E_A3,
   input  logic [RAW-1:0]   M_A3,
   input  logic [RAW-1:0]   W_A3,
   input  logic [1:0]       E_tnew,
   input  logic [1:0]       M_tnew,
   input  logic             md_start,
   input  logic             md_is_div,
   input  logic             stat_clr,
   output logic             stall,
   output logic [1:0]       fw_D_rs,
   output logic [1:0]       fw_D_rt,
   output logic [1:0]       fw_E_rs,
   output logic [1:0]       fw_E_rt,
   output logic             fw_M_rt,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             md_state
);

   localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
   localparam int MD_W   = $clog2(MD_MAX + 1);

   typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

   md_state_t       state, state_n;
   logic [MD_W-1:0] cnt, cnt_n;
   logic            data_stall, md_stall;

   // A reader stalls only when a producer in E or M will not have its result in time.
   always_comb begin
      data_stall = 1'b0;
      if (D_A1 != '0) begin
         if (E_A3 == D_A1 && E_tnew > D_tuse1) data_stall = 1'b1;
         if (M_A3 == D_A1 && M_tnew > D_tuse1) data_stall = 1'b1;
      end
      if (D_A2 != '0) begin
         if (E_A3 == D_A2 && E_tnew > D_tuse2) data_stall = 1'b1;
         if (M_A3 == D_A2 && M_tnew > D_tuse2) data_stall = 1'b1;
      end
   end

   assign md_busy  = (state == MD_BUSY);
   assign md_state = md_busy;
   assign md_stall = D_is_md && (md_start || md_busy);
   assign stall    = data_stall || md_stall;

   always_comb begin
      fw_D_rs = 2'd0;
      if (D_A1 != '0) begin
         if (E_A3 == D_A1 && E_tnew == 2'd0)      fw_D_rs = 2'd3;
         else if (M_A3 == D_A1 && M_tnew == 2'd0) fw_D_rs = 2'd2;
         else if (W_A3 == D_A1)                   fw_D_rs = 2'd1;
      end
      fw_D_rt = 2'd0;
      if (D_A2 != '0) begin
         if (E_A3 == D_A2 && E_tnew == 2'd0)      fw_D_rt = 2'd3;
         else if (M_A3 == D_A2 && M_tnew == 2'd0) fw_D_rt = 2'd2;
         else if (W_A3 == D_A2)                   fw_D_rt = 2'd1;
      end
   end

   always_comb begin
      fw_E_rs = 2'd0;
      if (E_A1 != '0) begin
         if (M_A3 == E_A1 && M_tnew == 2'd0) fw_E_rs = 2'd2;
         else if (W_A3 == E_A1)              fw_E_rs = 2'd1;
      end
      fw_E_rt = 2'd0;
      if (E_A2 != '0) begin
         if (M_A3 == E_A2 && M_tnew == 2'd0) fw_E_rt = 2'd2;
         else if (W_A3 == E_A2)              fw_E_rt = 2'd1;
      end
      fw_M_rt = (M_A2 != '0) && (W_A3 == M_A2);
   end

   // cnt holds the remaining busy cycles including the current one.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         MD_IDLE: begin
            if (md_start) begin
               state_n = MD_BUSY;
               cnt_n   = md_is_div ? MD_W'(DIV_LAT) : MD_W'(MULT_LAT);
            end
         end
         MD_BUSY: begin
            cnt_n = cnt - 1'b1;
            if (cnt == MD_W'(1)) state_n = MD_IDLE;
         end
         default: begin
            state_n = MD_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= MD_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                         stall_cnt <= '0;
      else if (stat_clr)                  stall_cnt <= '0;
      else if (stall && stall_cnt != '1)  stall_cnt <= stall_cnt + 1'b1;
   end

endmodule
